apb_alu: RTL and testbench

Execution-side slave pair for the KISC-V core: an APB-style memory target with byte-lane sizing, plus the combinational RV32I integer ALU and branch comparator. The microcode sequencer drives the bus control bits and the decoded operation. It consumes read data, ALU result and compare flag from this block. The ALU is purely combinational; the memory target is a small clocked state machine in front of an internal word RAM.

---
 rtl/apb_alu_if.sv | 23 ++
 rtl/apb_alu.sv | 200 ++++++++++++++++++++
 tb/tb_apb_alu.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/apb_alu_if.sv
// APB-style bus bundle between the microcode sequencer (master) and the
// apb_alu memory target (slave).
interface apb_alu_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;
  logic        en;
  logic        wr;
  logic [3:0]  dsize;
  logic        ready;
  logic        err;

  modport master (
    output addr, wdata, sel, en, wr, dsize,
    input  rdata, ready, err
  );

  modport slave (
    input  addr, wdata, sel, en, wr, dsize,
    output rdata, ready, err
  );
endinterface

// File: rtl/apb_alu.sv
// apb_alu: execution-side slave pair for the KISC-V core.
//   - APB-style memory target with byte-lane sizing in front of a word RAM.
//   - Combinational RV32I ALU and branch comparator.
// Build option: define APB_WAIT_EN to insert one wait cycle (ready=0) at the
// start of every access phase; the ALU is unaffected.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no transfer; waits for sel=1 with en=0
// S_SETUP  | setup phase; RAM word captured into the holding register
// S_WAIT   | first access cycle with ready=0 (only with APB_WAIT_EN)
// S_ACCESS | ready=1; completes when sel and en are both high
module apb_alu #(
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rts,
  apb_alu_if.slave        bus,
  input  logic [4:0]      alu_op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output logic [31:0]     alu_out,
  output logic            cmp_flag
);

  localparam int          LP_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] LP_LIMIT = 33'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_WAIT   = 2'd2,
    S_ACCESS = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic [31:0] r_hold;
  logic [31:0] r_mem [MEM_WORDS];

  logic [3:0]       w_size_eff;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_sh;
  logic [31:0]      w_rd_sh;
  logic [31:0]      w_rd_fmt;
  logic             w_misalign;
  logic             w_oor;
  logic             w_err_cond;
  logic             w_commit;
  logic [LP_AW-1:0] w_idx;

  // ---------------------------------------------------------------------
  // ALU and branch comparator
  // ---------------------------------------------------------------------
  logic [4:0] w_shamt;
  logic       w_eq;
  logic       w_lt_s;
  logic       w_lt_u;
  logic       w_unused_op3;

  assign w_shamt      = b[4:0];
  assign w_eq         = (a == b);
  assign w_lt_s       = ($signed(a) < $signed(b));
  assign w_lt_u       = (a < b);
  // alu_op[3] carries no meaning for this datapath.
  assign w_unused_op3 = alu_op[3];

  // ALU result selected by funct3; alt bit only matters for ADD/SUB and SRL/SRA.
  always_comb begin
    alu_out = '0;
    case (alu_op[2:0])
      3'd0: alu_out = alu_op[4] ? (a - b) : (a + b);
      3'd1: alu_out = a << w_shamt;
      3'd2: alu_out = {31'b0, w_lt_s};
      3'd3: alu_out = {31'b0, w_lt_u};
      3'd4: alu_out = a ^ b;
      3'd5: alu_out = alu_op[4] ? 32'($signed(a) >>> w_shamt) : (a >> w_shamt);
      3'd6: alu_out = a | b;
      3'd7: alu_out = a & b;
      default: alu_out = '0;
    endcase
  end

  // Branch condition selected by funct3 only.
  always_comb begin
    cmp_flag = 1'b0;
    case (alu_op[2:0])
      3'd0: cmp_flag = w_eq;
      3'd1: cmp_flag = ~w_eq;
      3'd2: cmp_flag = w_lt_s;
      3'd3: cmp_flag = w_lt_u;
      3'd4: cmp_flag = w_lt_s;
      3'd5: cmp_flag = ~w_lt_s;
      3'd6: cmp_flag = w_lt_u;
      3'd7: cmp_flag = ~w_lt_u;
      default: cmp_flag = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  // Unknown size codes behave as full-word transfers.
  always_comb begin
    case (bus.dsize)
      4'b0001: w_size_eff = 4'b0001;
      4'b0011: w_size_eff = 4'b0011;
      default: w_size_eff = 4'b1111;
    endcase
  end

  assign w_idx      = bus.addr[LP_AW+1:2];
  assign w_be       = w_size_eff << bus.addr[1:0];
  assign w_wdata_sh = bus.wdata << {bus.addr[1:0], 3'b000};
  assign w_misalign = ((w_size_eff == 4'b0011) & bus.addr[0]) |
                      ((w_size_eff == 4'b1111) & (|bus.addr[1:0]));
  assign w_oor      = ({1'b0, bus.addr} >= LP_LIMIT);
  assign w_err_cond = w_misalign | w_oor;

  // r_ready is only ever set while in S_ACCESS, so it doubles as the state decode.
  assign w_commit   = r_ready & bus.sel & bus.en & bus.wr & ~w_err_cond;

  // Lanes shifted down to bit 0, then masked and sign-extended by size.
  assign w_rd_sh = r_hold >> {bus.addr[1:0], 3'b000};
  always_comb begin
    case (w_size_eff)
      4'b0001: w_rd_fmt = {{24{w_rd_sh[7]}}, w_rd_sh[7:0]};
      4'b0011: w_rd_fmt = {{16{w_rd_sh[15]}}, w_rd_sh[15:0]};
      default: w_rd_fmt = w_rd_sh;
    endcase
  end

  assign bus.ready = r_ready;
  assign bus.err   = r_ready & w_err_cond;
  assign bus.rdata = (r_ready && !w_err_cond) ? w_rd_fmt : 32'h0;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  // Lane-masked store on the completing access edge; reset edges never commit.
  always_ff @(posedge clk) begin
    if (!rts && w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bus state machine with registered ready
  // ---------------------------------------------------------------------
  // Sequences IDLE -> SETUP -> (WAIT) -> ACCESS; sel low aborts to IDLE.
  always_ff @(posedge clk) begin
    if (rts) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.sel && !bus.en) r_state <= S_SETUP;
        end
        S_SETUP: begin
          if (!bus.sel) begin
            r_state <= S_IDLE;
          end else begin
            r_hold  <= r_mem[w_idx];
`ifdef APB_WAIT_EN
            r_state <= S_WAIT;
`else
            r_state <= S_ACCESS;
            r_ready <= 1'b1;
`endif
          end
        end
`ifdef APB_WAIT_EN
        S_WAIT: begin
          if (!bus.sel) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_ACCESS;
            r_ready <= 1'b1;
          end
        end
`endif
        S_ACCESS: begin
          if (!bus.sel || bus.en) begin
            r_state <= S_IDLE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_alu.sv
// Self-checking bench for apb_alu: table-driven ALU vectors plus a
// scoreboard-checked sequence of bus transfers and reset/abort corner cases.
module tb_apb_alu;

`ifdef APB_WAIT_EN
  localparam int LP_LAT = 2;
`else
  localparam int LP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rts = 1'b1;
  logic [4:0]  alu_op;
  logic [31:0] a, b;
  logic [31:0] alu_out;
  logic        cmp_flag;

  apb_alu_if bus();

  apb_alu #(.MEM_WORDS(1024), .INIT_FILE("")) dut (
    .clk      (clk),
    .rts      (rts),
    .bus      (bus),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .alu_out  (alu_out),
    .cmp_flag (cmp_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] out;
    logic        flag;
  } alu_vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
    string       name;
  } exp_t;

  alu_vec_t av[16];
  exp_t     sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 8) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic xfer(input logic wr_i, input logic [31:0] ad, input logic [31:0] wd,
                      input logic [3:0] ds, input logic e_err, input logic [31:0] e_rd,
                      input string nm);
    exp_t e;
    int   n;
    e.err = e_err; e.rdata = e_rd; e.chk_rd = ~wr_i; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    bus.sel = 1'b1; bus.en = 1'b0; bus.wr = wr_i;
    bus.addr = ad; bus.wdata = wd; bus.dsize = ds;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b1;
    wait_ready(n);
    chk({nm, "_lat"}, 32'(n), 32'(LP_LAT));
    e = sb.pop_front();
    if (bus.ready === 1'b1) begin
      chk({e.name, "_err"}, {31'b0, bus.err}, {31'b0, e.err});
      if (e.chk_rd) chk({e.name, "_rdata"}, bus.rdata, e.rdata);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s_timeout ready actual=0 expected=1", e.name);
    end
    @(posedge clk);
    #1;
    bus.sel = 1'b0; bus.en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.sel = 1'b0; bus.en = 1'b0; bus.wr = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.dsize = 4'hF;
    alu_op = '0; a = '0; b = '0;

    av[0]  = '{5'h00, 32'h8000_0000, 32'h1, 32'h8000_0001, 1'b0};
    av[1]  = '{5'h10, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0};
    av[2]  = '{5'h15, 32'h8000_0000, 32'h1, 32'hC000_0000, 1'b0};
    av[3]  = '{5'h05, 32'h8000_0000, 32'h1, 32'h4000_0000, 1'b0};
    av[4]  = '{5'h02, 32'h8000_0000, 32'h1, 32'h0000_0001, 1'b1};
    av[5]  = '{5'h03, 32'h8000_0000, 32'h1, 32'h0000_0000, 1'b0};
    av[6]  = '{5'h04, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b1};
    av[7]  = '{5'h06, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 1'b0};
    av[8]  = '{5'h05, 32'hFFFF_FFFF, 32'h1, 32'h7FFF_FFFF, 1'b0};
    av[9]  = '{5'h07, 32'hFFFF_FFFF, 32'h1, 32'h0000_0001, 1'b1};
    av[10] = '{5'h00, 32'h7, 32'h7, 32'h0000_000E, 1'b1};
    av[11] = '{5'h01, 32'h7, 32'h7, 32'h0000_0380, 1'b0};
    av[12] = '{5'h01, 32'h1234_5678, 32'h24, 32'h2345_6780, 1'b1};
    av[13] = '{5'h11, 32'h1234_5678, 32'h24, 32'h2345_6780, 1'b1};
    av[14] = '{5'h15, 32'h8000_0000, 32'h3F, 32'hFFFF_FFFF, 1'b0};
    av[15] = '{5'h10, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.ready}, 32'h0);
    chk("rst_err",   {31'b0, bus.err},   32'h0);
    chk("rst_rdata", bus.rdata,          32'h0);
    rts = 1'b0;

    // ALU table
    for (int i = 0; i < 16; i++) begin
      alu_op = av[i].op; a = av[i].va; b = av[i].vb;
      #1;
      chk($sformatf("alu_out_%0d", i), alu_out, av[i].out);
      chk($sformatf("cmp_flag_%0d", i), {31'b0, cmp_flag}, {31'b0, av[i].flag});
    end

    // Bus transfers
    xfer(1'b1, 32'h10,   32'hDEAD_BEEF, 4'hF,    1'b0, 32'h0,         "wr_word10");
    xfer(1'b1, 32'h11,   32'h55,        4'h1,    1'b0, 32'h0,         "wr_byte11");
    xfer(1'b0, 32'h10,   32'h0,         4'hF,    1'b0, 32'hDEAD_55EF, "rd_word10");
    xfer(1'b0, 32'h13,   32'h0,         4'h1,    1'b0, 32'hFFFF_FFDE, "rd_byte13");
    xfer(1'b0, 32'h12,   32'h0,         4'h3,    1'b0, 32'hFFFF_DEAD, "rd_half12");
    xfer(1'b0, 32'h10,   32'h0,         4'h3,    1'b0, 32'h0000_55EF, "rd_half10");
    xfer(1'b0, 32'h11,   32'h0,         4'h1,    1'b0, 32'h0000_0055, "rd_byte11");
    xfer(1'b0, 32'h10,   32'h0,         4'b0101, 1'b0, 32'hDEAD_55EF, "rd_oddsize");
    xfer(1'b1, 32'h20,   32'hA5A5_A5A5, 4'hF,    1'b0, 32'h0,         "wr_word20");
    xfer(1'b1, 32'h21,   32'hBEEF,      4'h3,    1'b1, 32'h0,         "wr_half21");
    xfer(1'b0, 32'h20,   32'h0,         4'hF,    1'b0, 32'hA5A5_A5A5, "rd_word20");
    xfer(1'b0, 32'h22,   32'h0,         4'hF,    1'b1, 32'h0,         "rd_word22");
    xfer(1'b0, 32'h1000, 32'h0,         4'hF,    1'b1, 32'h0,         "rd_oor");
    xfer(1'b1, 32'hFFF,  32'h9A,        4'h1,    1'b0, 32'h0,         "wr_lastbyte");
    xfer(1'b0, 32'hFFF,  32'h0,         4'h1,    1'b0, 32'hFFFF_FF9A, "rd_lastbyte");

    // Reset during the access cycle of a write
    xfer(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, "wr_word30");
    @(negedge clk);
    bus.sel = 1'b1; bus.en = 1'b0; bus.wr = 1'b1;
    bus.addr = 32'h30; bus.wdata = 32'h1234_5678; bus.dsize = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b1;
    wait_ready(n);
    chk("abort_ready_pre", {31'b0, bus.ready}, 32'h1);
    rts = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready_post", {31'b0, bus.ready}, 32'h0);
    chk("abort_err_post",   {31'b0, bus.err},   32'h0);
    chk("abort_rdata_post", bus.rdata,          32'h0);
    rts = 1'b0; bus.sel = 1'b0; bus.en = 1'b0;
    xfer(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D, "rd_word30");

    // Write abandoned by dropping sel without en must not store
    @(negedge clk);
    bus.sel = 1'b1; bus.en = 1'b0; bus.wr = 1'b1;
    bus.addr = 32'h20; bus.wdata = 32'h0; bus.dsize = 4'hF;
    repeat (4) @(negedge clk);
    bus.sel = 1'b0;
    @(negedge clk);
    chk("drop_ready", {31'b0, bus.ready}, 32'h0);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'hA5A5_A5A5, "rd_word20_drop");

    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
